// File: rtl/step_ctrl.sv
// step_ctrl: single-step / burst / free-run clock-enable controller for the CPU.
// Optional build macro: STEP_CTRL_RUN_DIV_EN. When it is defined, RUN mode
// enables the CPU once every 2^DIV_LOG2 cycles. When it is undefined, RUN
// enables the CPU every cycle and DIV_LOG2 is unused.
//
// Input semantics: step_pulse, burst_pulse and halt_clr are one-cycle pulses
// from the debouncer and are sampled on every rising edge. A pulse that the
// current state does not accept is dropped; it is never queued.
// run_sw and halt are levels. halt overrides everything else at every edge.
// All outputs are registered, so an input sampled at edge k shows up on
// cpu_en during the cycle that follows edge k.
module step_ctrl #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 32,
    parameter int DIV_LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_pulse,
    input  logic             burst_pulse,
    input  logic             run_sw,
    input  logic             halt,
    input  logic             halt_clr,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state_o,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_PAUSE  = 3'd0,
        ST_STEP   = 3'd1,
        ST_BURST  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_load_burst;
    logic [7:0]       r_burst_cnt;
    logic             r_cpu_en;
    logic             w_cpu_en_next;
    logic             w_run_en;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_busy;

    // State register; reset always returns to PAUSE, so a burst never resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; halt wins over every other input in every state.
    always_comb begin
        w_next       = r_state;
        w_load_burst = 1'b0;
        if (halt) begin
            w_next = ST_HALTED;
        end else begin
            case (r_state)
                ST_PAUSE: begin
                    if (run_sw) begin
                        w_next = ST_RUN;
                    end else if (burst_pulse) begin
                        w_next       = ST_BURST;
                        w_load_burst = 1'b1;
                    end else if (step_pulse) begin
                        w_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    w_next = ST_PAUSE;
                end
                ST_BURST: begin
                    // The count holds the enabled cycles left, including this one.
                    if (r_burst_cnt <= 8'd1) begin
                        w_next = run_sw ? ST_RUN : ST_PAUSE;
                    end
                end
                ST_RUN: begin
                    if (!run_sw) begin
                        w_next = ST_PAUSE;
                    end
                end
                ST_HALTED: begin
                    if (halt_clr) begin
                        w_next = ST_PAUSE;
                    end
                end
                default: begin
                    w_next = ST_PAUSE;
                end
            endcase
        end
    end

    // Burst counter: loaded on burst entry, decremented while the burst
    // continues, and cleared whenever the burst ends or is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 8'd0;
        end else if (w_load_burst) begin
            r_burst_cnt <= 8'(BURST_LEN);
        end else if (w_next == ST_BURST) begin
            r_burst_cnt <= r_burst_cnt - 8'd1;
        end else begin
            r_burst_cnt <= 8'd0;
        end
    end

`ifdef STEP_CTRL_RUN_DIV_EN
    logic [DIV_LOG2-1:0] r_div;
    logic [DIV_LOG2-1:0] w_div_next;

    // Divider phase for the cycle being entered: zero on RUN entry, else +1.
    always_comb begin
        w_div_next = '0;
        if (r_state == ST_RUN) begin
            w_div_next = r_div + DIV_LOG2'(1);
        end
        w_run_en = (w_div_next == '0);
    end

    // Divider register only advances while RUN continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_next == ST_RUN) begin
            r_div <= w_div_next;
        end else begin
            r_div <= '0;
        end
    end
`else
    // Without the divider RUN enables the CPU on every cycle.
    always_comb begin
        w_run_en = 1'b1;
    end
`endif

    // Enable for the cycle being entered, decoded from the next state.
    always_comb begin
        w_cpu_en_next = 1'b0;
        case (w_next)
            ST_STEP:  w_cpu_en_next = 1'b1;
            ST_BURST: w_cpu_en_next = 1'b1;
            ST_RUN:   w_cpu_en_next = w_run_en;
            default:  w_cpu_en_next = 1'b0;
        endcase
    end

    // Registered enable and busy flag, both aligned with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cpu_en <= w_cpu_en_next;
            r_busy   <= (w_next == ST_BURST) || (w_next == ST_RUN);
        end
    end

    // Enabled-cycle counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (r_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign cpu_en    = r_cpu_en;
    assign cycle_cnt = r_cycle_cnt;
    assign state_o   = r_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed and randomized bench for step_ctrl. A second instance
// with a 4-bit counter shares all inputs so that counter wrap can be observed.
module tb_step_ctrl;

    localparam int BURST_LEN = 16;
    localparam int CNT_W     = 32;
    localparam int DIV_LOG2  = 2;

    localparam int M_PAUSE  = 0;
    localparam int M_STEP   = 1;
    localparam int M_BURST  = 2;
    localparam int M_RUN    = 3;
    localparam int M_HALTED = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic step_pulse = 1'b0;
    logic burst_pulse = 1'b0;
    logic run_sw = 1'b0;
    logic halt = 1'b0;
    logic halt_clr = 1'b0;

    logic             cpu_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       state_o;
    logic             busy;

    logic       cpu_en4;
    logic [3:0] cycle_cnt4;
    logic [2:0] state_o4;
    logic       busy4;

    always #5 clk = ~clk;

    step_ctrl #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W), .DIV_LOG2(DIV_LOG2)) u_dut (
        .clk(clk), .rst_n(rst_n), .step_pulse(step_pulse), .burst_pulse(burst_pulse),
        .run_sw(run_sw), .halt(halt), .halt_clr(halt_clr),
        .cpu_en(cpu_en), .cycle_cnt(cycle_cnt), .state_o(state_o), .busy(busy)
    );

    step_ctrl #(.BURST_LEN(BURST_LEN), .CNT_W(4), .DIV_LOG2(DIV_LOG2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .step_pulse(step_pulse), .burst_pulse(burst_pulse),
        .run_sw(run_sw), .halt(halt), .halt_clr(halt_clr),
        .cpu_en(cpu_en4), .cycle_cnt(cycle_cnt4), .state_o(state_o4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // The model tracks the operating mode, enabled cycles left in a burst and
    // the cycle index inside a run, and derives enable from those quantities.
    int          m_mode;
    int          m_left;
    int          m_run_idx;
    bit          m_en;
    logic [31:0] m_cnt;

    function automatic bit run_cycle_enabled(input int idx);
`ifdef STEP_CTRL_RUN_DIV_EN
        return (idx % (1 << DIV_LOG2)) == 0;
`else
        return (idx >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_mode    = M_PAUSE;
        m_left    = 0;
        m_run_idx = 0;
        m_en      = 1'b0;
        m_cnt     = '0;
    endtask

    task automatic model_edge(input bit s, input bit b, input bit r, input bit h, input bit hc);
        if (m_en) m_cnt = m_cnt + 32'd1;
        if (h) begin
            m_mode = M_HALTED;
        end else begin
            case (m_mode)
                M_PAUSE: begin
                    if (r) begin
                        m_mode = M_RUN; m_run_idx = 0;
                    end else if (b) begin
                        m_mode = M_BURST; m_left = BURST_LEN;
                    end else if (s) begin
                        m_mode = M_STEP;
                    end
                end
                M_STEP: m_mode = M_PAUSE;
                M_BURST: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (r) begin
                            m_mode = M_RUN; m_run_idx = 0;
                        end else begin
                            m_mode = M_PAUSE;
                        end
                    end
                end
                M_RUN: begin
                    if (!r) m_mode = M_PAUSE;
                    else m_run_idx = m_run_idx + 1;
                end
                default: begin
                    if (hc) m_mode = M_PAUSE;
                end
            endcase
        end
        m_en = (m_mode == M_STEP) || (m_mode == M_BURST) ||
               ((m_mode == M_RUN) && run_cycle_enabled(m_run_idx));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input bit s, input bit b, input bit r, input bit h, input bit hc);
        step_pulse  = s;
        burst_pulse = b;
        run_sw      = r;
        halt        = h;
        halt_clr    = hc;
        model_edge(s, b, r, h, hc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        step_pulse = 0; burst_pulse = 0; run_sw = 0; halt = 0; halt_clr = 0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_step();
        do_reset();
        drive(1, 0, 0, 0, 0);
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL step_en_hi: got %0b want 1", cpu_en); end
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL step_state: got %0d want 1", state_o); end
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL step_en_lo: got %0b want 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== 32'd1) begin n_err++; $display("FAIL step_cnt: got %0d want 1", cycle_cnt); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL step_back: got %0d want 0", state_o); end
    endtask

    task automatic test_burst(input bit with_step);
        int seen;
        seen = 0;
        do_reset();
        drive(with_step, 1, 0, 0, 0);
        n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL burst_state: got %0d want 2", state_o); end
        for (int i = 0; i < 22; i++) begin
            n_cmp++; if (cpu_en !== m_en) begin n_err++; $display("FAIL burst_en[%0d]: got %0b want %0b", i, cpu_en, m_en); end
            if (cpu_en === 1'b1) seen++;
            drive((i == 4), 0, 0, 0, 0);
        end
        n_cmp++; if (seen != BURST_LEN) begin n_err++; $display("FAIL burst_len: got %0d want %0d", seen, BURST_LEN); end
        n_cmp++; if (cycle_cnt !== 32'(BURST_LEN)) begin n_err++; $display("FAIL burst_cnt: got %0d want %0d", cycle_cnt, BURST_LEN); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL burst_end_state: got %0d want 0", state_o); end
    endtask

    task automatic test_run();
        int want;
`ifdef STEP_CTRL_RUN_DIV_EN
        want = 100 / (1 << DIV_LOG2);
`else
        want = 100;
`endif
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1, 0, 0);
            n_cmp++; if (cpu_en !== m_en) begin n_err++; $display("FAIL run_en[%0d]: got %0b want %0b", i, cpu_en, m_en); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy[%0d]: got %0b want 1", i, busy); end
        end
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL run_stop_en: got %0b want 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== 32'(want)) begin n_err++; $display("FAIL run_cnt: got %0d want %0d", cycle_cnt, want); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL run_stop_state: got %0d want 0", state_o); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL halt_en: got %0b want 0", cpu_en); end
        n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL halt_state: got %0d want 4", state_o); end
        n_cmp++; if (cycle_cnt !== 32'd7) begin n_err++; $display("FAIL halt_cnt: got %0d want 7", cycle_cnt); end
        drive(1, 1, 1, 1, 1);
        n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL halt_clr_blocked: got %0d want 4", state_o); end
        drive(1, 1, 1, 0, 0);
        n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL halt_ignores_inputs: got %0d want 4", state_o); end
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL halt_clr: got %0d want 0", state_o); end
        n_cmp++; if (cycle_cnt !== 32'd7) begin n_err++; $display("FAIL halt_cnt_hold: got %0d want 7", cycle_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL midrst_en: got %0b want 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== '0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", cycle_cnt); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL midrst_state: got %0d want 0", state_o); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0);
            n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL midrst_resume[%0d]: got %0b want 0", i, cpu_en); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
        n_cmp++; if (cycle_cnt4 !== 4'd1) begin n_err++; $display("FAIL wrap_cnt4: got %0d want 1", cycle_cnt4); end
        n_cmp++; if (cycle_cnt !== 32'd17) begin n_err++; $display("FAIL wrap_cnt32: got %0d want 17", cycle_cnt); end
    endtask

    task automatic test_random();
        bit r, h;
        r = 0; h = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) r = ~r;
            if ($urandom_range(0, 79) == 0) h = ~h;
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0), r, h,
                  ($urandom_range(0, 5) == 0));
            n_cmp++; if (cpu_en !== m_en) begin n_err++; $display("FAIL rnd_en[%0d]: got %0b want %0b", i, cpu_en, m_en); end
            n_cmp++; if (state_o !== 3'(m_mode)) begin n_err++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state_o, m_mode); end
            n_cmp++; if (cycle_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cycle_cnt, m_cnt); end
            n_cmp++; if (cycle_cnt4 !== m_cnt[3:0]) begin n_err++; $display("FAIL rnd_cnt4[%0d]: got %0d want %0d", i, cycle_cnt4, m_cnt[3:0]); end
            n_cmp++; if (busy !== ((m_mode == M_BURST) || (m_mode == M_RUN))) begin n_err++; $display("FAIL rnd_busy[%0d]: got %0b mode %0d", i, busy, m_mode); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        #1;
        test_reset();
        test_step();
        test_burst(1'b0);
        test_burst(1'b1);
        test_run();
        test_halt();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
